// File: rtl/bank_arbiter_rr.sv
// bank_arbiter_rr
//   Per-bank round-robin arbiter with its own word storage. One instance sits
//   in front of each memory bank. It only considers requests whose address
//   bank field matches bank_n and serves one of them per access.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   bank_n     number of this bank (change only while idle with no eligible core)
//   read       per-core read request
//   write      per-core write request (read+write together is a write)
//   addr_in    per-core {bank, offset} address slices
//   data_in    per-core write data slices
//   data_out   per-core read data slices, registered, held between reads
//   finish     one-hot completion pulse to the served core, registered
//   busy       high while an access is in progress (ACCESS or DONE)
//   serv_core  index of the granted core, valid while busy
module bank_arbiter_rr #(
   parameter int N_CORES  = 16,
   parameter int CORE_W   = 4,
   parameter int BANK_W   = 4,
   parameter int OFFS_W   = 8,
   parameter int DATA_W   = 8,
   parameter int BANK_LAT = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [BANK_W-1:0]             bank_n,
   input  logic [N_CORES-1:0]            read,
   input  logic [N_CORES-1:0]            write,
   input  logic [N_CORES*(BANK_W+OFFS_W)-1:0] addr_in,
   input  logic [N_CORES*DATA_W-1:0]     data_in,
   output logic [N_CORES*DATA_W-1:0]     data_out,
   output logic [N_CORES-1:0]            finish,
   output logic                          busy,
   output logic [CORE_W-1:0]             serv_core
);

   localparam int AW    = BANK_W + OFFS_W;
   localparam int CNT_W = (BANK_LAT > 1) ? $clog2(BANK_LAT) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]        state;
   logic [CORE_W-1:0] ptr;
   logic [CORE_W-1:0] grant;
   logic [CNT_W-1:0]  cnt;
   logic              op_wr;
   logic [OFFS_W-1:0] offs_q;
   logic [DATA_W-1:0] wdata_q;

   logic [DATA_W-1:0] mem [2**OFFS_W];

   logic [N_CORES-1:0] elig;
   logic [N_CORES-1:0] cand;
   logic               found;
   logic [CORE_W-1:0]  win;
   logic [CORE_W:0]    idx;
   logic [CORE_W-1:0]  ptr_next;
   logic               win_wr;
   logic [OFFS_W-1:0]  win_offs;
   logic [DATA_W-1:0]  win_data;
   logic               cnt_last;

   // Eligibility: any request whose bank field addresses this bank.
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_CORES; i++) begin
         elig[i] = (read[i] | write[i]) &&
                   (addr_in[i*AW + OFFS_W +: BANK_W] == bank_n);
      end
   end

   // In DONE the just-served core is masked so that a core still holding its
   // request in its finish cycle cannot be granted twice in a row.
   always_comb begin
      cand = elig;
      if (state == DONE) begin
         cand[grant] = 1'b0;
      end
   end

   // Round-robin scan starting at ptr; idx is one bit wider so ptr+k never
   // overflows before the modulo correction.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < N_CORES; k++) begin
         idx = {1'b0, ptr} + (CORE_W+1)'(k);
         if (idx >= (CORE_W+1)'(N_CORES)) begin
            idx = idx - (CORE_W+1)'(N_CORES);
         end
         if (!found && cand[idx[CORE_W-1:0]]) begin
            found = 1'b1;
            win   = idx[CORE_W-1:0];
         end
      end
   end

   always_comb begin
      ptr_next = (win == CORE_W'(N_CORES-1)) ? '0 : win + CORE_W'(1);
      win_wr   = write[win];
      win_offs = addr_in[win*AW +: OFFS_W];
      win_data = data_in[win*DATA_W +: DATA_W];
      cnt_last = (cnt == CNT_W'(BANK_LAT-1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         grant    <= '0;
         cnt      <= '0;
         op_wr    <= 1'b0;
         finish   <= '0;
         data_out <= '0;
      end else begin
         finish <= '0;
         case (state)
            IDLE, DONE: begin
               if (found) begin
                  grant   <= win;
                  ptr     <= ptr_next;
                  op_wr   <= win_wr;
                  offs_q  <= win_offs;
                  wdata_q <= win_data;
                  cnt     <= '0;
                  state   <= ACCESS;
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               if (cnt_last) begin
                  state         <= DONE;
                  finish[grant] <= 1'b1;
                  // Memory cannot change during a read access, so sampling it
                  // here equals sampling it at the first ACCESS edge.
                  if (!op_wr) begin
                     data_out[grant*DATA_W +: DATA_W] <= mem[offs_q];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write commits at the edge ending the first ACCESS cycle, never on a
   // reset edge. Storage itself is not cleared by reset.
   always_ff @(posedge clock) begin
      if (!reset && state == ACCESS && cnt == '0 && op_wr) begin
         mem[offs_q] <= wdata_q;
      end
   end

   assign busy      = (state != IDLE);
   assign serv_core = grant;

endmodule

// File: tb/tb_bank_arbiter_rr.sv
module tb_bank_arbiter_rr;

   logic              clock = 1'b0;
   logic              reset;
   logic [3:0]        bank_n;
   logic [15:0]       read;
   logic [15:0]       write;
   logic [16*12-1:0]  addr_in;
   logic [127:0]      data_in;

   logic [127:0]      data_out;
   logic [15:0]       finish;
   logic              busy;
   logic [3:0]        serv_core;

   logic [127:0]      data_out3;
   logic [15:0]       finish3;
   logic              busy3;
   logic [3:0]        serv_core3;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clock = ~clock;

   bank_arbiter_rr #(.BANK_LAT(1)) u_dut (
      .clock(clock), .reset(reset), .bank_n(bank_n),
      .read(read), .write(write), .addr_in(addr_in), .data_in(data_in),
      .data_out(data_out), .finish(finish), .busy(busy), .serv_core(serv_core)
   );

   bank_arbiter_rr #(.BANK_LAT(3)) u_dut3 (
      .clock(clock), .reset(reset), .bank_n(bank_n),
      .read(read), .write(write), .addr_in(addr_in), .data_in(data_in),
      .data_out(data_out3), .finish(finish3), .busy(busy3), .serv_core(serv_core3)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int core, input logic rd, input logic wr,
                          input logic [3:0] bank, input logic [7:0] offs,
                          input logic [7:0] d);
      read[core]             = rd;
      write[core]            = wr;
      addr_in[core*12 +: 12] = {bank, offs};
      data_in[core*8 +: 8]   = d;
   endtask

   task automatic clear_req();
      read    = '0;
      write   = '0;
      addr_in = '0;
      data_in = '0;
   endtask

   task automatic do_reset();
      clear_req();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if (data_out !== 128'h0) $display("FAIL rst_data_out: got %h expected 0", data_out);
      else pass_cnt++;
      total_cnt++;
      if (finish !== 16'h0) $display("FAIL rst_finish: got %h expected 0", finish);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0 || serv_core !== 4'd0)
         $display("FAIL rst_busy_serv: got busy=%b serv=%0d expected 0/0", busy, serv_core);
      else pass_cnt++;
      total_cnt++;
      if (busy3 !== 1'b0 || finish3 !== 16'h0 || data_out3 !== 128'h0)
         $display("FAIL rst_lat3: got busy=%b finish=%h expected 0/0", busy3, finish3);
      else pass_cnt++;
   endtask

   task automatic test_write_read();
      do_reset();
      set_req(3, 1'b0, 1'b1, 4'h2, 8'h10, 8'hA5);
      tick();
      total_cnt++;
      if (busy !== 1'b1 || serv_core !== 4'd3 || finish !== 16'h0)
         $display("FAIL wr_cycle1: got busy=%b serv=%0d finish=%h expected 1/3/0000",
                  busy, serv_core, finish);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (finish !== 16'h0008) $display("FAIL wr_finish: got %h expected 0008", finish);
      else pass_cnt++;
      set_req(3, 1'b0, 1'b0, 4'h2, 8'h10, 8'hA5);
      tick();
      total_cnt++;
      if (busy !== 1'b0 || finish !== 16'h0)
         $display("FAIL wr_idle: got busy=%b finish=%h expected 0/0000", busy, finish);
      else pass_cnt++;
      set_req(3, 1'b1, 1'b0, 4'h2, 8'h10, 8'h00);
      tick();
      tick();
      total_cnt++;
      if (finish !== 16'h0008) $display("FAIL rd_finish: got %h expected 0008", finish);
      else pass_cnt++;
      total_cnt++;
      if (data_out !== (128'hA5 << 24))
         $display("FAIL rd_data: got %h expected %h", data_out, 128'hA5 << 24);
      else pass_cnt++;
      set_req(3, 1'b0, 1'b0, 4'h2, 8'h10, 8'h00);
      tick();
      tick();
      total_cnt++;
      if (data_out !== (128'hA5 << 24))
         $display("FAIL rd_hold: got %h expected %h", data_out, 128'hA5 << 24);
      else pass_cnt++;
   endtask

   task automatic test_both_rw();
      do_reset();
      set_req(0, 1'b1, 1'b1, 4'h2, 8'h20, 8'h77);
      tick();
      tick();
      total_cnt++;
      if (finish !== 16'h0001) $display("FAIL rw_finish: got %h expected 0001", finish);
      else pass_cnt++;
      total_cnt++;
      if (data_out[7:0] !== 8'h00) $display("FAIL rw_data_unchanged: got %h expected 00", data_out[7:0]);
      else pass_cnt++;
      set_req(0, 1'b0, 1'b0, 4'h2, 8'h20, 8'h00);
      tick();
      set_req(0, 1'b1, 1'b0, 4'h2, 8'h20, 8'h00);
      tick();
      tick();
      total_cnt++;
      if (data_out[7:0] !== 8'h77) $display("FAIL rw_readback: got %h expected 77", data_out[7:0]);
      else pass_cnt++;
      set_req(0, 1'b0, 1'b0, 4'h2, 8'h20, 8'h00);
      tick();
   endtask

   task automatic test_bank_filter();
      do_reset();
      set_req(1, 1'b1, 1'b0, 4'h7, 8'h01, 8'h00);
      set_req(5, 1'b0, 1'b1, 4'h7, 8'h02, 8'h99);
      for (int c = 0; c < 4; c++) begin
         tick();
         total_cnt++;
         if (busy !== 1'b0 || finish !== 16'h0)
            $display("FAIL filter_c%0d: got busy=%b finish=%h expected 0/0000", c, busy, finish);
         else pass_cnt++;
      end
      clear_req();
   endtask

   task automatic test_contention();
      logic [15:0] exp;
      do_reset();
      for (int i = 0; i < 16; i++) set_req(i, 1'b0, 1'b1, 4'h2, 8'h40 + 8'(i), 8'(i));
      for (int i = 0; i < 16; i++) begin
         tick();
         total_cnt++;
         if (busy !== 1'b1 || serv_core !== 4'(i) || finish !== 16'h0)
            $display("FAIL cont_grant_%0d: got busy=%b serv=%0d finish=%h expected 1/%0d/0000",
                     i, busy, serv_core, finish, i);
         else pass_cnt++;
         tick();
         exp = 16'h1 << i;
         total_cnt++;
         if (busy !== 1'b1 || finish !== exp)
            $display("FAIL cont_finish_%0d: got busy=%b finish=%h expected 1/%h", i, busy, finish, exp);
         else pass_cnt++;
         set_req(i, 1'b0, 1'b0, 4'h2, 8'h40 + 8'(i), 8'(i));
      end
      tick();
      total_cnt++;
      if (busy !== 1'b0 || finish !== 16'h0)
         $display("FAIL cont_end: got busy=%b finish=%h expected 0/0000", busy, finish);
      else pass_cnt++;
   endtask

   task automatic test_latency();
      logic [15:0] exp;
      do_reset();
      set_req(4, 1'b0, 1'b1, 4'h2, 8'h80, 8'h44);
      set_req(9, 1'b0, 1'b1, 4'h2, 8'h81, 8'h99);
      for (int c = 1; c <= 8; c++) begin
         tick();
         exp = (c == 4) ? 16'h0010 : (c == 8) ? 16'h0200 : 16'h0000;
         total_cnt++;
         if (finish3 !== exp)
            $display("FAIL lat3_cycle%0d: got finish=%h expected %h", c, finish3, exp);
         else pass_cnt++;
         if (c == 5) begin
            total_cnt++;
            if (serv_core3 !== 4'd9 || busy3 !== 1'b1)
               $display("FAIL lat3_second_grant: got serv=%0d busy=%b expected 9/1", serv_core3, busy3);
            else pass_cnt++;
         end
         if (c == 4) set_req(4, 1'b0, 1'b0, 4'h2, 8'h80, 8'h44);
         if (c == 8) set_req(9, 1'b0, 1'b0, 4'h2, 8'h81, 8'h99);
      end
      tick();
      set_req(3, 1'b0, 1'b1, 4'h2, 8'h82, 8'h33);
      set_req(10, 1'b0, 1'b1, 4'h2, 8'h83, 8'hAA);
      tick();
      total_cnt++;
      if (serv_core3 !== 4'd10 || busy3 !== 1'b1)
         $display("FAIL lat3_ptr: got serv=%0d busy=%b expected 10/1", serv_core3, busy3);
      else pass_cnt++;
      clear_req();
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      set_req(6, 1'b0, 1'b1, 4'h2, 8'h00, 8'h11);
      tick();
      tick();
      set_req(6, 1'b0, 1'b0, 4'h2, 8'h00, 8'h11);
      tick();
      set_req(6, 1'b0, 1'b1, 4'h2, 8'h00, 8'h3C);
      tick();
      reset = 1'b1;
      set_req(6, 1'b0, 1'b0, 4'h2, 8'h00, 8'h3C);
      tick();
      reset = 1'b0;
      total_cnt++;
      if (data_out !== 128'h0 || finish !== 16'h0 || busy !== 1'b0 || serv_core !== 4'd0)
         $display("FAIL midrst_outputs: got finish=%h busy=%b serv=%0d expected all 0",
                  finish, busy, serv_core);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (finish !== 16'h0) $display("FAIL midrst_no_finish: got %h expected 0000", finish);
      else pass_cnt++;
      set_req(6, 1'b1, 1'b0, 4'h2, 8'h00, 8'h00);
      tick();
      tick();
      total_cnt++;
      if (finish !== 16'h0040 || data_out !== (128'h11 << 48))
         $display("FAIL midrst_readback: got finish=%h data=%h expected 0040/%h",
                  finish, data_out, 128'h11 << 48);
      else pass_cnt++;
      clear_req();
      tick();
   endtask

   initial begin
      reset  = 1'b1;
      bank_n = 4'h2;
      clear_req();
      test_reset();
      test_write_read();
      test_both_rw();
      test_bank_filter();
      test_contention();
      test_latency();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/bank_arbiter_rr.md
# bank_arbiter_rr

Parametrised per-bank arbiter with its own storage. It serves up to N_CORES cores against one memory bank and sits between the core array and shared memory, with one instance per bank. A request is considered only when its bank-select field equals the instance's bank number, and one of those requests is granted per access in round-robin order. The bank latency is configurable, a back-to-back grant is issued without an idle cycle, and the finish pulse goes to exactly the served core.

## Interface
- N_CORES, 16: number of requesting cores; must be ≥2.
- CORE_W, 4: index width; must equal ceil(log2(N_CORES)).
- BANK_W, 4: width of the bank-select field.
- OFFS_W, 8: width of the in-bank word offset; the bank depth is 2^OFFS_W words.
- DATA_W, 8: word width.
- BANK_LAT, 1: cycles spent in ACCESS, ≥1.

- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- bank_n  in  BANK_W  number of this bank; static during operation.
- read  in  N_CORES  per-core read request.
- write  in  N_CORES  per-core write request.
- addr_in  in  N_CORES*(BANK_W+OFFS_W)  per-core address; slice i is {bank[BANK_W-1:0], offset[OFFS_W-1:0]}.
- data_in  in  N_CORES*DATA_W  per-core write data, slice i.
- data_out  out  N_CORES*DATA_W  per-core read data, slice i; registered.
- finish  out  N_CORES  one-hot completion pulse; registered.
- busy  out  1  high while in ACCESS or DONE.
- serv_core  out  CORE_W  index of the granted core; valid while busy.

## Operation
- Eligibility: core i is eligible when (read[i] | write[i]) is high and the bank field of addr slice i equals bank_n. Non-matching requests are ignored completely.
- Arbitration: the arbiter scans indices ptr, ptr+1, … modulo N_CORES and grants the first eligible core. After each grant, ptr becomes grant+1, wrapping from N_CORES-1 to 0.
- FSM states:
  - IDLE: if any core is eligible, latch the grant, op, offset and data, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: count BANK_LAT cycles, then go to DONE.
    - A write commits to memory at the clock edge that ends the first ACCESS cycle.
    - A read samples memory at the same edge.
  - DONE: finish[g] is high and all other finish bits are low.
    - Arbitrate again with core g masked out. If a winner exists, go to ACCESS with the new grant; otherwise go to IDLE.
- Operation type: read and write both high on the same core is treated as a write, and data_out is not updated.
- data_out on a read: slice g is loaded with the read word on the edge entering DONE.
- data_out otherwise: all other slices, and slice g on a write, hold their previous value. No X is ever driven.
- Request holding: a core holds its request, address and data stable until it sees finish. It drops the request by the cycle after finish.
  - If it keeps the request high, it is re-granted only in round-robin turn.
- Memory contents: not cleared by reset, and undefined until written.

## Timing
- Eligible request first seen in IDLE in cycle 0:
  - busy = 1 from cycle 1.
  - finish[g] = 1 in cycle BANK_LAT+1.
  - Read data is valid in data_out slice g in cycle BANK_LAT+1 and held afterwards.
- Throughput under continuous contention: one access per BANK_LAT+1 cycles, because the grant taken in DONE removes the IDLE gap.
- finish is exactly one cycle wide and at most one bit is high in any cycle.
- Input sampling: inputs are sampled only in IDLE and DONE. Changes during ACCESS have no effect.
- Reset values, taking effect on the edge with reset high:
  - state = IDLE, ptr = 0, finish = 0, data_out = 0, busy = 0, serv_core = 0.
- Reset priority: reset overrides everything. A write whose commit edge coincides with reset is not committed, and an in-flight read is dropped with no finish.
- bank_n change: only allowed while IDLE with no eligible core; otherwise behaviour is undefined.

## Test plan
- Write then read, BANK_LAT=1, bank_n=2:
  - Core 3 writes 0xA5 to offset 0x10 → finish = 16'h0008 in cycle 2.
  - Core 3 then reads offset 0x10 → data_out[31:24] = 0xA5 with finish = 16'h0008; all other data_out slices stay 0.
- Full contention: all 16 cores request with bank=2 from reset.
  - Grants are issued in order 0,1,…,15, one per 2 cycles, with no IDLE between.
  - Each core drops its request after its finish; busy goes low only after core 15.
- Bank filtering: cores 1 and 5 request with bank=7 while bank_n=2 → no grant, busy stays 0, finish stays 0.
- Latency, BANK_LAT=3: cores 4 and 9 request together.
  - finish[4] is high in cycle 4 and finish[9] in cycle 8.
  - ptr ends at 10, so core 10 would be served next.
- Reset mid-write: core 6 writes 0x3C to offset 0x00 (known 0x11), with reset asserted on the first ACCESS cycle's edge.
  - All outputs are 0 next cycle and no finish is issued.
  - A subsequent read of offset 0x00 returns 0x11.
- Read and write together: core 0 asserts both with data 0x77 → memory is written 0x77, data_out[7:0] is unchanged, and finish = 16'h0001.
